pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined successor to the 4-bit ripple-carry adder.
//   Splits a WIDTH-bit add/subtract into CHUNK-bit ripple segments, one pipeline stage per segment.
//   Accepts one operation per cycle under a valid/ready handshake and returns {carry, sum} plus signed overflow.
//   Sits in the datapath lab as the reusable arithmetic unit.
// PARAMETERS
//   WIDTH    16  operand width in bits; must be a multiple of CHUNK
//   CHUNK     4  bits rippled per stage; NSTAGES = WIDTH/CHUNK (localparam); WIDTH%CHUNK!=0 -> elaboration $error
// PORTS
//   clk        in   1        rising-edge clock; single clock domain
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand bundle valid
//   in_ready   out  1        block can accept operands this cycle
//   a          in   WIDTH    operand A (unsigned or two's complement)
//   b          in   WIDTH    operand B
//   cin        in   1        carry-in (add) / borrow-in (sub)
//   sub        in   1        0: A+B+cin; 1: A-B-cin
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   sum        out  WIDTH+1  {carry_out, result}; sub: bit WIDTH = 1 means no borrow
//   ovf        out  1        signed overflow of the WIDTH-bit result
// BEHAVIOUR
//   - Arithmetic: add: a + b + cin. Sub: a + ~b + !cin, i.e. A-B-cin mod 2^WIDTH.
//   - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
//   - Pipeline: stage k (0..NSTAGES-1) adds bits [k*CHUNK +: CHUNK] with the carry registered by stage k-1.
//   - Stage 0 takes the effective carry-in.
//   - Untouched upper operand chunks and finished lower result chunks travel in skew registers beside each stage.
//   - Every stage carries a valid bit.
//   - Stall: advance = !out_valid | out_ready; in_ready = advance (combinational).
//   - advance=0: every stage register, valid bit and output holds.
//   - Bubbles are not collapsed.
//   - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//   - Latency: exactly NSTAGES cycles from an accepted input to out_valid, with no stalls in between.
//   - Each stall cycle adds one cycle.
//   - Throughput: 1 result per cycle when out_ready is held high.
//   - Ordering: results leave strictly in acceptance order. No drop, no duplicate.
//   - sum/ovf are stable while out_valid & !out_ready.
//   - Outputs are registered. sum/ovf are don't-care when out_valid=0, but must not be X after reset.
//   - Reset (rst_n low, asynchronous, any cycle incl. mid-stream):
//       all valid bits=0, out_valid=0, sum=0, ovf=0, all datapath registers=0.
//     In-flight operations are discarded.
//     in_ready=1 during and after reset (out_valid=0).
//   - Boundaries:
//       all-ones + 1 -> carry ripples through every stage: sum = {1, 0}.
//       NSTAGES=1 -> single-register adder, latency 1.
//       simultaneous accept-in and deliver-out in one cycle is legal.
//       in_valid=0 while advancing injects a bubble (valid=0).
// TESTING (WIDTH=16, CHUNK=4, latency 4)
//   1. Reset: assert rst_n=0 mid-stream with 3 ops in flight.
//      -> out_valid=0 and sum=0 at once; in_ready=1; no stale result ever emerges after release.
//   2. a=FFFF b=0001 cin=0 sub=0 -> 4 cycles later out_valid=1, sum=1_0000, ovf=0.
//   3. a=7FFF b=0001 cin=0 sub=0 -> sum=0_8000, ovf=1.
//      a=8000 b=8000 -> sum=1_0000, ovf=1.
//   4. Subtract cases:
//      a=0005 b=0007 cin=0 sub=1 -> sum=0_FFFE, ovf=0.
//      a=0007 b=0005 cin=1 sub=1 -> sum=1_0001.
//      a=8000 b=0001 sub=1 cin=0 -> sum=1_7FFF, ovf=1.
//   5. Backpressure: 8 back-to-back ops, out_ready=0 for 3 cycles after the first result.
//      -> in_ready=0 in those cycles; out data held; all 8 results delivered in order.
//   6. 2000 random ops with random in_valid/out_ready.
//      -> every result matches the reference model; output count equals input count.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master drives operands and out_ready; the slave (the adder) drives in_ready and results.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    output sub,
    input  out_valid,
    output out_ready,
    input  sum,
    input  ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    input  sub,
    output out_valid,
    input  out_ready,
    output sum,
    output ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple segment per stage, valid/ready
// handshake with a single global stall, registered {carry, sum} and signed overflow.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_addsub_if.slave   bus
);

  localparam int unsigned NSTAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
  end

  logic               w_advance;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff;
  logic [CHUNK:0]     w_chunk;
  logic               w_x_msb;
  logic               w_y_msb;

  // Per-stage state: r_a/r_b carry the operands forward (only the upper chunks still matter),
  // r_res accumulates finished lower chunks, r_cy is the carry out of the stage's chunk.
  logic [NSTAGES-1:0] r_vld;
  logic [NSTAGES-1:0] w_vld_d;
  logic [NSTAGES-1:0] r_cy;
  logic [NSTAGES-1:0] w_cy_d;
  logic [WIDTH-1:0]   r_a     [NSTAGES];
  logic [WIDTH-1:0]   w_a_d   [NSTAGES];
  logic [WIDTH-1:0]   r_b     [NSTAGES];
  logic [WIDTH-1:0]   w_b_d   [NSTAGES];
  logic [WIDTH-1:0]   r_res   [NSTAGES];
  logic [WIDTH-1:0]   w_res_d [NSTAGES];
  logic               r_ovf;
  logic               w_ovf_d;

  function automatic logic [CHUNK:0] f_chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  assign w_advance = !r_vld[NSTAGES-1] || bus.out_ready;

  // Subtraction is folded into operand inversion so every stage is a plain adder.
  assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
  assign w_cin_eff = bus.sub ? ~bus.cin : bus.cin;

  always_comb begin
    w_vld_d = '0;
    w_cy_d  = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      w_a_d[k]   = '0;
      w_b_d[k]   = '0;
      w_res_d[k] = '0;
    end

    w_chunk    = f_chunk_add(bus.a[0 +: CHUNK], w_b_eff[0 +: CHUNK], w_cin_eff);
    w_x_msb    = bus.a[CHUNK-1];
    w_y_msb    = w_b_eff[CHUNK-1];
    w_vld_d[0] = bus.in_valid;
    w_cy_d[0]  = w_chunk[CHUNK];
    w_a_d[0]   = bus.a;
    w_b_d[0]   = w_b_eff;
    w_res_d[0][0 +: CHUNK] = w_chunk[CHUNK-1:0];

    for (int k = 1; k < NSTAGES; k++) begin
      w_chunk    = f_chunk_add(r_a[k-1][k*CHUNK +: CHUNK], r_b[k-1][k*CHUNK +: CHUNK],
                               r_cy[k-1]);
      w_x_msb    = r_a[k-1][k*CHUNK + CHUNK - 1];
      w_y_msb    = r_b[k-1][k*CHUNK + CHUNK - 1];
      w_vld_d[k] = r_vld[k-1];
      w_cy_d[k]  = w_chunk[CHUNK];
      w_a_d[k]   = r_a[k-1];
      w_b_d[k]   = r_b[k-1];
      w_res_d[k] = r_res[k-1];
      w_res_d[k][k*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
    end

    // After the loop w_chunk/w_x_msb/w_y_msb belong to the last stage; x^y^s recovers the
    // carry into the MSB, which is XORed with the carry out.
    w_ovf_d = w_x_msb ^ w_y_msb ^ w_chunk[CHUNK-1] ^ w_chunk[CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_cy  <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < NSTAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
    end else if (w_advance) begin
      r_vld <= w_vld_d;
      r_cy  <= w_cy_d;
      r_ovf <= w_ovf_d;
      for (int k = 0; k < NSTAGES; k++) begin
        r_a[k]   <= w_a_d[k];
        r_b[k]   <= w_b_d[k];
        r_res[k] <= w_res_d[k];
      end
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_vld[NSTAGES-1];
  assign bus.sum       = {r_cy[NSTAGES-1], r_res[NSTAGES-1]};
  assign bus.ovf       = r_ovf;

endmodule
